// File: rtl/apb_cfg_pkg.sv
// apb_cfg_pkg: shared opcodes, FSM state encoding and script entry layout
// for the apb_cfg_sequencer APB configuration master.
package apb_cfg_pkg;

  localparam int DEF_ADDRESSWIDTH = 5;
  localparam int DEF_DATAWIDTH    = 16;
  localparam int DEF_DEPTH        = 64;
  localparam int DEF_PTR_W        = 6;
  localparam int DEF_TIMEOUT      = 255;

  // Script opcodes; the reserved code executes like END.
  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_WAIT  = 2'd1,
    OP_END   = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SETUP,
    ST_ACCESS,
    ST_WAIT,
    ST_RSETUP,
    ST_RACCESS,
    ST_DONE,
    ST_ERROR
  } state_e;

  // Script entry layout, MSB first: {opcode, apb address, data/count}.
  function automatic int entry_width(input int aw, input int dw);
    return 2 + aw + dw;
  endfunction

  localparam int ENTRY_W = entry_width(DEF_ADDRESSWIDTH, DEF_DATAWIDTH);

endpackage

// File: rtl/apb_cfg_sequencer_if.sv
// apb_cfg_sequencer_if: APB bus between the sequencer (master) and the
// peripheral register ports (slave).
interface apb_cfg_sequencer_if #(
  parameter int ADDRESSWIDTH = 5,
  parameter int DATAWIDTH    = 16
);
  logic [ADDRESSWIDTH-1:0] PADDR_o;
  logic [DATAWIDTH-1:0]    PWDATA_o;
  logic                    PWRITE_o;
  logic                    PSELx_o;
  logic                    PENABLE_o;
  logic                    PREADY_i;
  logic [DATAWIDTH-1:0]    PRDATA_i;

  modport master (
    output PADDR_o, PWDATA_o, PWRITE_o, PSELx_o, PENABLE_o,
    input  PREADY_i, PRDATA_i
  );

  modport slave (
    input  PADDR_o, PWDATA_o, PWRITE_o, PSELx_o, PENABLE_o,
    output PREADY_i, PRDATA_i
  );
endinterface

// File: rtl/apb_cfg_script_ram.sv
// apb_cfg_script_ram: DEPTH x ENTRY_W script store, one write port and one
// registered read port.
module apb_cfg_script_ram
  import apb_cfg_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int PTR_W   = DEF_PTR_W,
  parameter int ENTRY_W = apb_cfg_pkg::ENTRY_W
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [PTR_W-1:0]   waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic [PTR_W-1:0]   raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  // Write the addressed entry and register the read entry every cycle.
  // NOTE: array and read register carry no reset so this maps onto a RAM;
  // the sequencer always fetches an entry before it uses it.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/apb_cfg_sequencer.sv
// apb_cfg_sequencer: APB master that replays a stored WRITE/WAIT/END script
// into the peripheral register ports and reports done or error.
// Optional feature macro APB_READBACK_EN: every WRITE is followed by a read
// of the same address whose data must match, else the script errors.
module apb_cfg_sequencer
  import apb_cfg_pkg::*;
#(
  parameter int ADDRESSWIDTH = DEF_ADDRESSWIDTH,
  parameter int DATAWIDTH    = DEF_DATAWIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int PTR_W        = DEF_PTR_W,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    tbl_we_i,
  input  logic [PTR_W-1:0]        tbl_waddr_i,
  input  logic [1:0]              tbl_wop_i,
  input  logic [ADDRESSWIDTH-1:0] tbl_waddr_apb_i,
  input  logic [DATAWIDTH-1:0]    tbl_wdata_i,
  input  logic                    start_i,
  input  logic                    abort_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [PTR_W-1:0]        err_idx_o,
  apb_cfg_sequencer_if.master     apb
);

  localparam int EW    = entry_width(ADDRESSWIDTH, DATAWIDTH);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [DATAWIDTH-1:0]    cnt_q, cnt_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0]    data_q, data_d;
  logic                    abort_q, abort_d;
  logic                    error_q, error_d;
  logic [PTR_W-1:0]        err_idx_q, err_idx_d;

  logic [EW-1:0]           ent;
  op_e                     ent_op;
  logic [ADDRESSWIDTH-1:0] ent_addr;
  logic [DATAWIDTH-1:0]    ent_data;
  state_e                  adv_state;

  // The read address follows ptr_d so the entry is valid during FETCH.
  apb_cfg_script_ram #(
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W),
    .ENTRY_W(EW)
  ) u_ram (
    .clk    (PCLK),
    .we_i   (tbl_we_i && !busy_o),
    .waddr_i(tbl_waddr_i),
    .wdata_i({tbl_wop_i, tbl_waddr_apb_i, tbl_wdata_i}),
    .raddr_i(ptr_d),
    .rdata_o(ent)
  );

  assign ent_op   = op_e'(ent[EW-1 -: 2]);
  assign ent_addr = ent[DATAWIDTH +: ADDRESSWIDTH];
  assign ent_data = ent[DATAWIDTH-1:0];

  // State register and datapath registers, synchronous reset.
  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      abort_q   <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      abort_q   <= abort_d;
      error_q   <= error_d;
      err_idx_q <= err_idx_d;
    end
  end

  // Next-state logic: script walk, WAIT count, ACCESS timeout, abort latch.
  always_comb begin
    // NOTE: every target gets a default first, so no latch can be inferred.
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    addr_d    = addr_q;
    data_d    = data_q;
    abort_d   = abort_q | abort_i;
    error_d   = error_q;
    err_idx_d = err_idx_q;
    // Where a finished entry goes: stop on abort or after the last index.
    adv_state = (abort_d || ptr_q == PTR_LAST) ? ST_DONE : ST_FETCH;

    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (start_i) begin
          state_d   = ST_FETCH;
          ptr_d     = '0;
          error_d   = 1'b0;
          err_idx_d = '0;
        end
      end
      ST_FETCH: begin
        addr_d = ent_addr;
        data_d = ent_data;
        cnt_d  = ent_data;
        if (abort_d) begin
          state_d = ST_DONE;
        end else begin
          case (ent_op)
            OP_WRITE: state_d = ST_SETUP;
            OP_WAIT:  state_d = ST_WAIT;
            default:  state_d = ST_DONE;
          endcase
        end
      end
      ST_SETUP: begin
        tmo_d   = '0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb.PREADY_i) begin
`ifdef APB_READBACK_EN
          state_d = ST_RSETUP;
`else
          state_d = adv_state;
          ptr_d   = ptr_q + PTR_W'(1);
`endif
        end else if (tmo_q == TMO_LAST) begin
          state_d   = ST_ERROR;
          error_d   = 1'b1;
          err_idx_d = ptr_q;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
`ifdef APB_READBACK_EN
      ST_RSETUP: begin
        tmo_d   = '0;
        state_d = ST_RACCESS;
      end
      ST_RACCESS: begin
        if (apb.PREADY_i) begin
          if (apb.PRDATA_i != data_q) begin
            state_d   = ST_ERROR;
            error_d   = 1'b1;
            err_idx_d = ptr_q;
          end else begin
            state_d = adv_state;
            ptr_d   = ptr_q + PTR_W'(1);
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d   = ST_ERROR;
          error_d   = 1'b1;
          err_idx_d = ptr_q;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
`endif
      ST_WAIT: begin
        if (abort_d) begin
          state_d = ST_DONE;
        end else if (cnt_q <= DATAWIDTH'(1)) begin
          state_d = adv_state;
          ptr_d   = ptr_q + PTR_W'(1);
        end else begin
          cnt_d = cnt_q - DATAWIDTH'(1);
        end
      end
      ST_DONE, ST_ERROR: begin
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state; address/data held in registers.
  always_comb begin
    busy_o        = (state_q != ST_IDLE);
    done_o        = (state_q == ST_DONE);
    error_o       = error_q;
    err_idx_o     = err_idx_q;
    apb.PSELx_o   = state_q inside {ST_SETUP, ST_ACCESS, ST_RSETUP, ST_RACCESS};
    apb.PENABLE_o = state_q inside {ST_ACCESS, ST_RACCESS};
    apb.PWRITE_o  = state_q inside {ST_SETUP, ST_ACCESS};
    apb.PADDR_o   = addr_q;
    apb.PWDATA_o  = data_q;
  end

`ifndef APB_READBACK_EN
  logic unused_prdata;
  assign unused_prdata = ^apb.PRDATA_i;
`endif

endmodule
